sti_dac_gen2: RTL

Parametrised serial-transmit / pixel-memory-write engine: accepts a parallel word on `load`, transmits a packet of 8–`8*2^LEN_W` bits serially on `so_data`/`so_valid`, and writes the same bit stream byte-by-byte into a pixel memory. On `pi_end` it pads the remaining memory with a fill value and raises `pixel_finish`. Compared with the current STI/DAC block it adds:
- a `pi_ready` handshake,
- parametrised data width and memory depth,
- overflow detection,
- a fixed one-cycle write latency per byte.

---
 rtl/sti_dac_gen2_pkg.sv | 18 +
 rtl/sti_dac_gen2_if.sv | 34 +++
 rtl/sti_dac_gen2_shift_unit.sv | 81 ++++++++
 rtl/sti_dac_gen2.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sti_dac_gen2_pkg.sv
// Shared types and helpers for the serial-transmit / pixel-memory engine.
package sti_dac_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FILL  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Packet length in bits for a given length code.
   function automatic int pkt_bits(input int code);
      return BYTE_W * (code + 1);
   endfunction

endpackage

// File: rtl/sti_dac_gen2_if.sv
// Host-side bus of the engine: packet load, serial output and pixel-memory write port.
interface sti_dac_gen2_if #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 2,
   parameter int ADDR_W = 8
);
   logic              load;
   logic [DATA_W-1:0] pi_data;
   logic [LEN_W-1:0]  pi_length;
   logic              pi_fill;
   logic              pi_msb;
   logic              pi_low;
   logic              pi_end;
   logic              pi_ready;
   logic              so_data;
   logic              so_valid;
   logic              pixel_wr;
   logic [ADDR_W-1:0] pixel_addr;
   logic [7:0]        pixel_dataout;
   logic              pixel_finish;
   logic              pixel_overflow;

   modport master (
      output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
      input  pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout,
             pixel_finish, pixel_overflow
   );

   modport slave (
      input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
      output pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout,
             pixel_finish, pixel_overflow
   );
endinterface

// File: rtl/sti_dac_gen2_shift_unit.sv
// Packet builder and bit serialiser. Outputs describe the bit emitted at the coming edge,
// so the parent can register them straight into its ports.
module sti_shift_unit
   import sti_dac_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   input  logic [LEN_W-1:0]  length,
   input  logic              fill,
   input  logic              msb,
   input  logic              low,
   output logic              serial_bit,
   output logic              bit_valid,
   output logic              byte_done,
   output logic [BYTE_W-1:0] byte_data,
   output logic              busy
);
   localparam int MAX_L = BYTE_W << LEN_W;
   localparam int W     = (MAX_L > DATA_W) ? MAX_L : DATA_W;
   localparam int CNT_W = $clog2(MAX_L + 1);
   localparam int POS_W = $clog2(BYTE_W);

   int               len_bits;
   logic [W-1:0]     ext;
   logic [W-1:0]     just;
   logic [MAX_L-1:0] seq;

   logic [MAX_L-1:0]  pkt_reg;
   logic [CNT_W-1:0]  remain_reg;
   logic [BYTE_W-2:0] acc_reg;
   logic [POS_W-1:0]  pos_reg;

   // Justify the payload into L bits, then reorder so transmit order is always bit 0 upward.
   always_comb begin
      len_bits = pkt_bits(int'(length));
      ext      = W'(data);
      if (len_bits < DATA_W)
         just = low ? (ext >> (DATA_W - len_bits)) : ext;
      else if (len_bits > DATA_W)
         just = fill ? (ext << (len_bits - DATA_W)) : ext;
      else
         just = ext;
      just = just & ~({W{1'b1}} << len_bits);
      seq  = '0;
      for (int i = 0; i < MAX_L; i++) begin
         if (i < len_bits)
            seq[i] = msb ? just[len_bits - 1 - i] : just[i];
      end
   end

   assign busy       = (remain_reg != '0);
   assign bit_valid  = start | busy;
   assign serial_bit = start ? seq[0] : pkt_reg[0];
   assign byte_done  = !start && busy && (pos_reg == POS_W'(BYTE_W - 1));
   assign byte_data  = {acc_reg, serial_bit};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_reg    <= '0;
         remain_reg <= '0;
         acc_reg    <= '0;
         pos_reg    <= '0;
      end else if (start) begin
         pkt_reg    <= seq >> 1;
         remain_reg <= CNT_W'(len_bits - 1);
         acc_reg    <= {acc_reg[BYTE_W-3:0], seq[0]};
         pos_reg    <= POS_W'(1);
      end else if (busy) begin
         pkt_reg    <= pkt_reg >> 1;
         remain_reg <= remain_reg - CNT_W'(1);
         acc_reg    <= {acc_reg[BYTE_W-3:0], pkt_reg[0]};
         pos_reg    <= pos_reg + POS_W'(1);
      end
   end

endmodule

// File: rtl/sti_dac_gen2.sv
// Serial-transmit / pixel-memory-write engine: control FSM, address counter,
// end-of-session fill and sticky status flags around the shift unit.
module sti_dac_gen2
   import sti_dac_pkg::*;
#(
   parameter int         DATA_W     = 16,
   parameter int         LEN_W      = 2,
   parameter int         MEM_DEPTH  = 256,
   parameter int         ADDR_W     = $clog2(MEM_DEPTH),
   parameter logic [7:0] FILL_VALUE = 8'h00
) (
   input logic          clk,
   input logic          reset,
   sti_dac_gen2_if.slave bus
);
   localparam logic [1:0] IDLE  = S_IDLE;
   localparam logic [1:0] SHIFT = S_SHIFT;
   localparam logic [1:0] FILL  = S_FILL;
   localparam logic [1:0] DONE  = S_DONE;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   logic [1:0]        state_reg;
   logic              ready_reg;
   logic              so_data_reg;
   logic              so_valid_reg;
   logic              wr_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        dout_reg;
   logic              finish_reg;
   logic              overflow_reg;
   logic              written_reg;

   logic              start;
   logic              full;
   logic [ADDR_W-1:0] free_addr;
   logic              serial_bit;
   logic              bit_valid;
   logic              byte_done;
   logic [7:0]        byte_data;
   logic              busy;

   assign start     = (state_reg == IDLE) && bus.load;
   // addr_reg doubles as "last written address" once anything has been written.
   assign full      = written_reg && (addr_reg == LAST_ADDR);
   assign free_addr = written_reg ? addr_reg + ADDR_W'(1) : '0;

   sti_shift_unit #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_shift (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .data       (bus.pi_data),
      .length     (bus.pi_length),
      .fill       (bus.pi_fill),
      .msb        (bus.pi_msb),
      .low        (bus.pi_low),
      .serial_bit (serial_bit),
      .bit_valid  (bit_valid),
      .byte_done  (byte_done),
      .byte_data  (byte_data),
      .busy       (busy)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         ready_reg    <= 1'b1;
         so_data_reg  <= 1'b0;
         so_valid_reg <= 1'b0;
         wr_reg       <= 1'b0;
         addr_reg     <= '0;
         dout_reg     <= '0;
         finish_reg   <= 1'b0;
         overflow_reg <= 1'b0;
         written_reg  <= 1'b0;
      end else begin
         wr_reg       <= 1'b0;
         so_valid_reg <= bit_valid;
         if (bit_valid)
            so_data_reg <= serial_bit;
         if (byte_done) begin
            if (full) begin
               overflow_reg <= 1'b1;
            end else begin
               wr_reg      <= 1'b1;
               addr_reg    <= free_addr;
               dout_reg    <= byte_data;
               written_reg <= 1'b1;
            end
         end
         case (state_reg)
            IDLE: begin
               if (bus.load) begin
                  state_reg <= SHIFT;
                  ready_reg <= 1'b0;
               end else if (bus.pi_end) begin
                  ready_reg <= 1'b0;
                  if (full) begin
                     state_reg  <= DONE;
                     finish_reg <= 1'b1;
                  end else begin
                     // First fill byte goes out in the cycle right after pi_end.
                     state_reg   <= FILL;
                     wr_reg      <= 1'b1;
                     addr_reg    <= free_addr;
                     dout_reg    <= FILL_VALUE;
                     written_reg <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (!busy) begin
                  state_reg <= IDLE;
                  ready_reg <= 1'b1;
               end
            end
            FILL: begin
               if (addr_reg == LAST_ADDR) begin
                  state_reg  <= DONE;
                  finish_reg <= 1'b1;
               end else begin
                  wr_reg   <= 1'b1;
                  addr_reg <= addr_reg + ADDR_W'(1);
                  dout_reg <= FILL_VALUE;
               end
            end
            DONE: begin
               state_reg <= DONE;
            end
            default: begin
               state_reg <= IDLE;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign bus.pi_ready       = ready_reg;
   assign bus.so_data        = so_data_reg;
   assign bus.so_valid       = so_valid_reg;
   assign bus.pixel_wr       = wr_reg;
   assign bus.pixel_addr     = addr_reg;
   assign bus.pixel_dataout  = dout_reg;
   assign bus.pixel_finish   = finish_reg;
   assign bus.pixel_overflow = overflow_reg;

endmodule
